bus_responder: RTL and testbench
================================

BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 The block SHALL have parameter RAM_WORDS, default 512, giving the number of 32-bit words of data RAM; it SHALL be a power of two.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port MemRead, input, 1 bit: read request from the CPU MEM stage.
REQ-005 The block SHALL have port MemWrite, input, 1 bit: write request from the CPU MEM stage.
REQ-006 The block SHALL have port MemBus_Address, input, 32 bits: byte address; bits [1:0] are ignored.
REQ-007 The block SHALL have port MemBus_Write_Data, input, 32 bits: write data.
REQ-008 The block SHALL have port Device_Read_Data, output, 32 bits: read data returned to the CPU.
REQ-009 The block SHALL have port leds, output, 8 bits: LED register.
REQ-010 The block SHALL have port digits, output, 12 bits: seven-segment register (anode select [11:8], segments [7:0]).
REQ-011 The block SHALL have port irq, output, 1 bit: timer interrupt request.

Function
REQ-012 The address map SHALL be: RAM at 0x00000000 to RAM_WORDS*4-1; TH at 0x40000000; TL at 0x40000004; TCON at 0x40000008; LEDS at 0x4000000C; DIGITS at 0x40000010; SYSTICK at 0x40000014.
REQ-013 Reads SHALL have zero latency: Device_Read_Data is a combinational function of the address and the current state while MemRead=1; it is 0 when MemRead=0.
REQ-014 Writes SHALL take effect at the rising clk edge in the cycle MemWrite=1; the new value is readable from the next cycle.
REQ-015 With MemRead=1 and MemWrite=1 together, the write SHALL occur and the read SHALL return the pre-write value.
REQ-016 Reads of unmapped addresses SHALL return 0; writes to unmapped addresses SHALL have no effect.
REQ-017 LEDS and DIGITS SHALL store bits [7:0] and [11:0] of the write data; reads SHALL return those bits zero-extended; the leds and digits outputs are driven directly from these registers.
REQ-018 SYSTICK SHALL be a free-running 32-bit counter: +1 every cycle, wrapping 0xFFFFFFFF to 0; it is read-only and writes are ignored.
REQ-019 TCON bits: [0] enable, [1] interrupt enable, [2] status; bits [31:3] SHALL read 0.
REQ-020 When TCON[0]=1, TL SHALL increment each cycle; when TL=0xFFFFFFFF it SHALL load TH instead (overflow).
REQ-021 On overflow with TCON[1]=1, TCON[2] SHALL be set.
REQ-022 irq SHALL equal TCON[1] AND TCON[2], registered-state only (no combinational path from bus inputs).
REQ-023 A CPU write to TL in the same cycle as an increment or overflow SHALL take priority: TL takes the written value.
REQ-024 A CPU write to TCON in the same cycle as an overflow SHALL update bits [1:0] from the write; bit 2 SHALL be set (status set wins over write-clear).
REQ-025 TCON[2] SHALL be cleared only by a CPU write with bit 2 = 0, or by reset.

Reset
REQ-026 On reset=1 at a clk edge: TH, TL, TCON, LEDS, DIGITS and SYSTICK SHALL become 0; leds=0, digits=0, irq=0.
REQ-027 Reset SHALL take priority over any simultaneous write or timer event.
REQ-028 RAM contents SHALL NOT be cleared by reset.

Structure
REQ-029 Address constants and TCON bit indices SHALL live in a shared package used by this block and its sub-module.
REQ-030 The timer (TH, TL, TCON, irq) SHALL be a sub-module named bus_timer; the RAM, LEDS, DIGITS, SYSTICK and read mux remain in bus_responder.

Verification
REQ-031 RAM write 0x12345678 to 0x00000010, then read 0x00000010 and 0x00000013 -> both return 0x12345678.
REQ-032 TH=0xFFFFFFFE, TL=0xFFFFFFFE, TCON=0x3 -> after 2 cycles TL=0xFFFFFFFE (reloaded), TCON reads 0x7, irq=1; write TCON=0x3 -> irq=0 next cycle.
REQ-033 TCON=0x1 and TL=5 -> TL increments each cycle; a TL write of 0x100 in an increment cycle -> TL reads 0x100 next cycle, 0x101 the cycle after.
REQ-034 Write TCON=0x3 in the same cycle as overflow -> TCON reads 0x7, irq=1.
REQ-035 Read 0x40000020 -> 0; a write there leaves all registers unchanged; a SYSTICK write is ignored and SYSTICK keeps counting.
REQ-036 Assert reset mid-count with irq=1 and LEDS=0xAA -> next cycle all registers read 0, irq=0, leds=0; previously written RAM words remain readable unchanged.

Source files
------------

// File: rtl/bus_responder_pkg.sv
// bus_responder_pkg: address map and TCON bit positions shared by the responder and its timer
package bus_responder_pkg;
  localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
  localparam logic [31:0] ADDR_LEDS    = 32'h4000_000C;
  localparam logic [31:0] ADDR_DIGITS  = 32'h4000_0010;
  localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0014;
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;
endpackage

// File: rtl/bus_timer.sv
// bus_timer: reloading TH/TL timer with TCON control/status and interrupt request
module bus_timer
  import bus_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we_th,
  input  logic        we_tl,
  input  logic        we_tcon,
  input  logic [31:0] wdata,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        irq
);
  logic ovf;
  assign ovf = tcon[TCON_EN] && (&tl);
  always_ff @(posedge clk)
    if (rst) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
    end else begin
      if (we_th) th <= wdata;
      tl <= we_tl ? wdata : !tcon[TCON_EN] ? tl : ovf ? th : tl + 32'd1;
      // a status set from overflow beats a simultaneous write-clear
      tcon[TCON_ST] <= (ovf && tcon[TCON_IE]) || (we_tcon ? wdata[TCON_ST] : tcon[TCON_ST]);
      if (we_tcon) tcon[TCON_IE:TCON_EN] <= wdata[TCON_IE:TCON_EN];
    end
  assign irq = tcon[TCON_IE] & tcon[TCON_ST];
endmodule

// File: rtl/bus_responder.sv
// bus_responder: memory-mapped RAM, LED/digit registers, systick and timer with zero-latency reads
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter int RAM_WORDS = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] MemBus_Address,
  input  logic [31:0] MemBus_Write_Data,
  output logic [31:0] Device_Read_Data,
  output logic [7:0]  leds,
  output logic [11:0] digits,
  output logic        irq
);
  localparam int AW = $clog2(RAM_WORDS);
  logic [31:0] ram [RAM_WORDS];
  logic [31:0] addr, th, tl, systick;
  logic [2:0]  tcon;
  logic        ram_hit;
  logic [AW-1:0] idx;
  assign addr    = {MemBus_Address[31:2], 2'b00};
  assign ram_hit = MemBus_Address[31:AW+2] == '0;
  assign idx     = MemBus_Address[AW+1:2];
  bus_timer u_timer (
    .clk     (clk),
    .rst     (reset),
    .we_th   (MemWrite && addr == ADDR_TH),
    .we_tl   (MemWrite && addr == ADDR_TL),
    .we_tcon (MemWrite && addr == ADDR_TCON),
    .wdata   (MemBus_Write_Data),
    .th      (th),
    .tl      (tl),
    .tcon    (tcon),
    .irq     (irq)
  );
  always_ff @(posedge clk)
    if (MemWrite && ram_hit) ram[idx] <= MemBus_Write_Data;
  always_ff @(posedge clk)
    if (reset) begin
      leds    <= '0;
      digits  <= '0;
      systick <= '0;
    end else begin
      systick <= systick + 32'd1;
      if (MemWrite && addr == ADDR_LEDS) leds <= MemBus_Write_Data[7:0];
      if (MemWrite && addr == ADDR_DIGITS) digits <= MemBus_Write_Data[11:0];
    end
  always_comb
    Device_Read_Data = !MemRead              ? '0 :
                       ram_hit               ? ram[idx] :
                       addr == ADDR_TH       ? th :
                       addr == ADDR_TL       ? tl :
                       addr == ADDR_TCON     ? {29'd0, tcon} :
                       addr == ADDR_LEDS     ? {24'd0, leds} :
                       addr == ADDR_DIGITS   ? {20'd0, digits} :
                       addr == ADDR_SYSTICK  ? systick : '0;
endmodule

// File: tb/tb_bus_responder.sv
// tb_bus_responder: randomized and directed checks of bus_responder against a behavioural model
module tb_bus_responder;
  localparam int W = 512;
  logic        clk = 0, reset = 0, MemRead = 0, MemWrite = 0;
  logic [31:0] MemBus_Address = 0, MemBus_Write_Data = 0;
  logic [31:0] Device_Read_Data;
  logic [7:0]  leds;
  logic [11:0] digits;
  logic        irq;
  int checks = 0, failures = 0;

  bus_responder #(.RAM_WORDS(W)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemBus_Address(MemBus_Address), .MemBus_Write_Data(MemBus_Write_Data),
    .Device_Read_Data(Device_Read_Data), .leds(leds), .digits(digits), .irq(irq)
  );

  always #5 clk = ~clk;

  logic [31:0] m_ram [W];
  bit          m_ok [W];
  logic [31:0] m_th, m_tl, m_tick, m_leds, m_digits;
  bit          m_en, m_ie, m_st;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w < 32'(W * 4)) return m_ram[w[31:2]];
    if (w == 32'h4000_0000) return m_th;
    if (w == 32'h4000_0004) return m_tl;
    if (w == 32'h4000_0008) return {29'd0, m_st, m_ie, m_en};
    if (w == 32'h4000_000C) return m_leds;
    if (w == 32'h4000_0010) return m_digits;
    if (w == 32'h4000_0014) return m_tick;
    return 0;
  endfunction

  function automatic bit m_irq();
    return m_ie && m_st;
  endfunction

  task automatic m_reset();
    m_th = 0; m_tl = 0; m_tick = 0; m_leds = 0; m_digits = 0;
    m_en = 0; m_ie = 0; m_st = 0;
  endtask

  task automatic m_clock(input bit wr, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] w, old_th;
    bit ovf, set_st;
    w = {a[31:2], 2'b00};
    old_th = m_th;
    ovf = m_en && m_tl == 32'hFFFF_FFFF;
    set_st = ovf && m_ie;
    m_tick = m_tick + 1;
    if (m_en) m_tl = ovf ? old_th : m_tl + 1;
    if (set_st) m_st = 1;
    if (wr) begin
      if (w < 32'(W * 4)) begin m_ram[w[31:2]] = d; m_ok[w[31:2]] = 1; end
      else if (w == 32'h4000_0000) m_th = d;
      else if (w == 32'h4000_0004) m_tl = d;
      else if (w == 32'h4000_0008) begin m_en = d[0]; m_ie = d[1]; m_st = set_st ? 1'b1 : d[2]; end
      else if (w == 32'h4000_000C) m_leds = {24'd0, d[7:0]};
      else if (w == 32'h4000_0010) m_digits = {20'd0, d[11:0]};
    end
  endtask

  task automatic step(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] got, output logic [31:0] exp);
    @(negedge clk);
    MemRead = rd; MemWrite = wr; MemBus_Address = a; MemBus_Write_Data = d;
    #1 got = Device_Read_Data;
    exp = rd ? m_read(a) : 32'd0;
    @(posedge clk);
    m_clock(wr, a, d);
    #1 MemRead = 0; MemWrite = 0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] got, output logic [31:0] exp);
    step(1, 0, a, 0, got, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] g, e;
    step(0, 1, a, d, g, e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    m_reset();
    #1 reset = 0;
  endtask

  task automatic test_reset();
    logic [31:0] g, e;
    do_reset();
    checks++; if (leds !== 0 || digits !== 0 || irq !== 0) begin failures++; $display("FAIL reset_outs leds=%h digits=%h irq=%b req 0", leds, digits, irq); end
    rd(32'h4000_0014, g, e);
    checks++; if (g !== 32'd0) begin failures++; $display("FAIL reset_systick got=%h req 0", g); end
    for (int i = 0; i < 5; i++) begin
      rd(32'h4000_0000 + 32'(i * 4), g, e);
      checks++; if (g !== 32'd0) begin failures++; $display("FAIL reset_reg%0d got=%h req 0", i, g); end
    end
    step(0, 0, 32'h4000_0014, 0, g, e);
    checks++; if (g !== 32'd0) begin failures++; $display("FAIL idle_read got=%h req 0", g); end
  endtask

  task automatic test_ram();
    logic [31:0] g, e;
    wr(32'h10, 32'h1234_5678);
    rd(32'h10, g, e);
    checks++; if (g !== 32'h1234_5678) begin failures++; $display("FAIL ram_10 got=%h req 12345678", g); end
    rd(32'h13, g, e);
    checks++; if (g !== 32'h1234_5678) begin failures++; $display("FAIL ram_13 got=%h req 12345678", g); end
    wr(32'(W * 4 - 4), 32'hCAFE_F00D);
    rd(32'(W * 4 - 4), g, e);
    checks++; if (g !== 32'hCAFE_F00D) begin failures++; $display("FAIL ram_top got=%h req cafef00d", g); end
    rd(32'(W * 4), g, e);
    checks++; if (g !== 32'd0) begin failures++; $display("FAIL ram_past_end got=%h req 0", g); end
  endtask

  task automatic test_leds_digits();
    logic [31:0] g, e, d;
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      wr(32'h4000_000C, d);
      checks++; if (leds !== d[7:0]) begin failures++; $display("FAIL leds_out got=%h req %h", leds, d[7:0]); end
      rd(32'h4000_000C, g, e);
      checks++; if (g !== e) begin failures++; $display("FAIL leds_rd got=%h req %h", g, e); end
      d = $urandom;
      wr(32'h4000_0010, d);
      checks++; if (digits !== d[11:0]) begin failures++; $display("FAIL digits_out got=%h req %h", digits, d[11:0]); end
      rd(32'h4000_0010, g, e);
      checks++; if (g !== e) begin failures++; $display("FAIL digits_rd got=%h req %h", g, e); end
    end
    step(1, 1, 32'h4000_000C, 32'h5A, g, e);
    checks++; if (g !== e) begin failures++; $display("FAIL rw_same_cycle got=%h req %h", g, e); end
    checks++; if (leds !== 8'h5A) begin failures++; $display("FAIL rw_same_leds got=%h req 5a", leds); end
  endtask

  task automatic test_overflow();
    logic [31:0] g, e;
    wr(32'h4000_0000, 32'hFFFF_FFFE);
    wr(32'h4000_0004, 32'hFFFF_FFFE);
    wr(32'h4000_0008, 32'h3);
    rd(32'h4000_0004, g, e);
    rd(32'h4000_0004, g, e);
    rd(32'h4000_0004, g, e);
    checks++; if (g !== 32'hFFFF_FFFE) begin failures++; $display("FAIL ovf_reload got=%h req fffffffe", g); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL ovf_irq got=%b req 1", irq); end
    rd(32'h4000_0008, g, e);
    checks++; if (g !== 32'h7) begin failures++; $display("FAIL ovf_tcon got=%h req 7", g); end
    wr(32'h4000_0008, 32'h3);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b req 0", irq); end
    wr(32'h4000_0008, 32'h0);
    wr(32'h4000_0004, 32'hFFFF_FFFF);
    wr(32'h4000_0008, 32'h3);
    wr(32'h4000_0008, 32'h3);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL ovf_write_irq got=%b req 1", irq); end
    rd(32'h4000_0008, g, e);
    checks++; if (g !== 32'h7) begin failures++; $display("FAIL ovf_write_tcon got=%h req 7", g); end
  endtask

  task automatic test_tl_priority();
    logic [31:0] g, e;
    wr(32'h4000_0008, 32'h1);
    wr(32'h4000_0004, 32'h5);
    rd(32'h4000_0004, g, e);
    checks++; if (g !== 32'h5) begin failures++; $display("FAIL tl_start got=%h req 5", g); end
    rd(32'h4000_0004, g, e);
    checks++; if (g !== 32'h6) begin failures++; $display("FAIL tl_inc got=%h req 6", g); end
    wr(32'h4000_0004, 32'h100);
    rd(32'h4000_0004, g, e);
    checks++; if (g !== 32'h100) begin failures++; $display("FAIL tl_write got=%h req 100", g); end
    rd(32'h4000_0004, g, e);
    checks++; if (g !== 32'h101) begin failures++; $display("FAIL tl_after got=%h req 101", g); end
    wr(32'h4000_0008, 32'h0);
  endtask

  task automatic test_unmapped();
    logic [31:0] g, e, t0;
    rd(32'h4000_0020, g, e);
    checks++; if (g !== 32'd0) begin failures++; $display("FAIL unmapped_rd got=%h req 0", g); end
    wr(32'h4000_0020, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      rd(32'h4000_0000 + 32'(i * 4), g, e);
      checks++; if (g !== e) begin failures++; $display("FAIL unmapped_wr_reg%0d got=%h req %h", i, g, e); end
    end
    rd(32'h4000_0014, t0, e);
    wr(32'h4000_0014, 32'h0);
    rd(32'h4000_0014, g, e);
    checks++; if (g !== t0 + 32'd2) begin failures++; $display("FAIL systick_wr got=%h req %h", g, t0 + 32'd2); end
    checks++; if (g !== e) begin failures++; $display("FAIL systick_model got=%h req %h", g, e); end
  endtask

  task automatic test_random();
    logic [31:0] g, e, a, d;
    bit r, w, chk;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 8))
        0, 1: a = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
        2: a = 32'h4000_0000;
        3, 4: a = 32'h4000_0004;
        5: a = 32'h4000_0008;
        6: a = $urandom_range(0, 1) ? 32'h4000_000C : 32'h4000_0010;
        7: a = 32'h4000_0014;
        default: a = 32'h4000_0018 + 32'($urandom_range(0, 60) * 4);
      endcase
      d = $urandom;
      if (a == 32'h4000_0004 && d[0]) d = 32'hFFFF_FFF0 | {28'd0, d[4:1]};
      if (a == 32'h4000_0008) d = {30'd0, d[1:0]};
      w = $urandom_range(0, 2) == 0;
      r = $urandom_range(0, 3) != 0;
      chk = !(a < 32'(W * 4)) || m_ok[a[31:2]];
      step(r, w, a, d, g, e);
      if (chk) begin
        checks++; if (g !== e) begin failures++; $display("FAIL rand_rd i=%0d addr=%h got=%h req %h", i, a, g, e); end
      end
      checks++; if (irq !== m_irq() || leds !== m_leds[7:0] || digits !== m_digits[11:0]) begin
        failures++; $display("FAIL rand_outs i=%0d irq=%b leds=%h digits=%h req %b %h %h", i, irq, leds, digits, m_irq(), m_leds[7:0], m_digits[11:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] g, e;
    wr(32'h10, 32'h1234_5678);
    wr(32'h4000_0008, 32'h0);
    wr(32'h4000_0004, 32'hFFFF_FFFF);
    wr(32'h4000_0008, 32'h3);
    wr(32'h4000_000C, 32'hAA);
    checks++; if (irq !== 1'b1 || leds !== 8'hAA) begin failures++; $display("FAIL pre_reset irq=%b leds=%h req 1 aa", irq, leds); end
    do_reset();
    checks++; if (irq !== 1'b0 || leds !== 8'h0 || digits !== 12'h0) begin failures++; $display("FAIL mid_reset irq=%b leds=%h digits=%h req 0", irq, leds, digits); end
    for (int i = 0; i < 5; i++) begin
      rd(32'h4000_0000 + 32'(i * 4), g, e);
      checks++; if (g !== 32'd0) begin failures++; $display("FAIL mid_reset_reg%0d got=%h req 0", i, g); end
    end
    rd(32'h10, g, e);
    checks++; if (g !== 32'h1234_5678) begin failures++; $display("FAIL ram_kept got=%h req 12345678", g); end
  endtask

  initial begin
    m_reset();
    for (int i = 0; i < W; i++) m_ok[i] = 0;
    test_reset();
    test_ram();
    test_leds_digits();
    test_overflow();
    test_tl_priority();
    test_unmapped();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
